data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WORD_SIZE, default 16, data and address width in bits.
REQ-002 Parameter MEM_WORDS, default 256, number of storage words; SHALL be a power of two.
REQ-003 Parameter LATENCY, default 2, number of cycles DataDone is held low per access; legal range 1..15.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 DataAddr  input  WORD_SIZE  word address of the access.
REQ-007 DataOut  input  WORD_SIZE  store data from the processor.
REQ-008 ReadData  input  1  load request.
REQ-009 WriteData  input  1  store request.
REQ-010 DataIn  output  WORD_SIZE  load result returned to the processor.
REQ-011 DataDone  output  1  high when the responder is not stalling the processor.
REQ-012 BusErr  output  1  one-cycle protocol-error pulse (present only with DMEM_ERR_CHECK_EN, see Configuration).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-014 DataDone SHALL be 1 in IDLE and RESP and 0 in BUSY, decoded from state only.
REQ-015 In IDLE or RESP, a request (ReadData|WriteData) SHALL capture the address, data and op, load cnt=LATENCY and enter BUSY on the next edge.
REQ-016 In BUSY, cnt SHALL decrement each cycle; the edge on which cnt reaches 0 SHALL move to RESP.
REQ-017 The RAM access SHALL occur on the BUSY->RESP edge: a store writes the captured data; a load registers mem[addr] into DataIn.
REQ-018 An access SHALL hold DataDone low for exactly LATENCY cycles, starting the cycle after the request.
REQ-019 In RESP with no request, the FSM SHALL go to IDLE; with a request, it SHALL accept the request and go to BUSY (back-to-back, no idle gap).
REQ-020 Request inputs SHALL be ignored in BUSY; the processor re-drives them there and they are not re-captured.
REQ-021 DataIn SHALL hold its last load value until the next load completes; stores SHALL NOT change DataIn.
REQ-022 Addresses SHALL wrap modulo MEM_WORDS, using only the low $clog2(MEM_WORDS) bits.
REQ-023 If ReadData and WriteData are both 1 at capture, the access SHALL be treated as a store.
REQ-024 A load after a store to the same address SHALL return the stored value.

Reset
REQ-025 Reset SHALL force state=IDLE, cnt=0, DataIn=0, DataDone=1 and BusErr=0 immediately.
REQ-026 Reset during BUSY SHALL abandon the access; a pending store SHALL NOT commit.
REQ-027 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro DMEM_ERR_CHECK_EN defined, BusErr SHALL pulse for 1 cycle when a read/write conflict is captured, or when in BUSY the request signals or DataAddr differ from the captured values.
REQ-029 Without DMEM_ERR_CHECK_EN, BusErr SHALL be constant 0, no checking logic SHALL be generated, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package mem_pkg SHALL hold the WORD_SIZE constant, the mem_state_t enum (IDLE, BUSY, RESP) and the mem_op_t enum (MEM_RD, MEM_WR).
REQ-031 Storage SHALL be a sub-module dmem_array: single-port synchronous RAM with we, addr, wdata and registered rdata.
REQ-032 The top level SHALL contain the FSM, the latency counter, the capture registers and the error checking.

Verification
REQ-033 Reset, then idle: DataDone=1, DataIn=0, BusErr=0.
REQ-034 Store 0xBEEF to addr 5 with LATENCY=2: DataDone low for cycles T+1 and T+2, high at T+3; a subsequent load of addr 5 gives DataIn=0xBEEF when DataDone rises.
REQ-035 Load from addr 261 with MEM_WORDS=256 returns the value stored at addr 5 (wrap-around).
REQ-036 Back-to-back: a load issued in the RESP cycle of a prior store is accepted with no IDLE cycle; DataDone pattern is 0,0,1,0,0,1.
REQ-037 Reset asserted mid-BUSY of a store of 0x1234 to addr 9: immediate IDLE and DataDone=1; a later load of addr 9 returns the old contents.
REQ-038 With DMEM_ERR_CHECK_EN, ReadData=WriteData=1 at capture: a store occurs and BusErr=1 for exactly 1 cycle; without the macro, BusErr stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// The optional protocol checker in data_mem_responder is enabled by
// defining DMEM_ERR_CHECK_EN.
package mem_pkg;

  // Default data/address width of the processor data port.
  localparam int WORD_SIZE = 16;

  // Width of the latency down-counter; holds LATENCY values 1..15.
  localparam int CNT_W = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Operation latched at capture time.
  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_t;

  // A simultaneous read and write request resolves to a store.
  function automatic mem_op_t decode_op(input logic rd, input logic wr);
    return (wr || !rd) ? MEM_WR : MEM_RD;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with a registered, enable-gated read port.
// The read register resets to zero so the processor sees a defined load
// result after reset; the storage array itself keeps its contents.
module dmem_array #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: commit store data on the access edge.
  // NOTE: the array has no reset branch on purpose -- contents survive reset
  // and a resettable array would not map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port: register the addressed word only when a load completes,
  // so rdata holds the last load value between loads.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: stalls the processor for LATENCY cycles per access
// via DataDone, then performs the RAM access on the BUSY->RESP edge.
// Optional protocol checker (BusErr) is built only when DMEM_ERR_CHECK_EN is
// defined; otherwise BusErr is tied low and no checking logic exists.
module data_mem_responder
  // Named imports keep the package WORD_SIZE apart from the parameter below.
  import mem_pkg::CNT_W, mem_pkg::mem_state_t, mem_pkg::mem_op_t,
         mem_pkg::IDLE, mem_pkg::BUSY, mem_pkg::RESP,
         mem_pkg::MEM_RD, mem_pkg::MEM_WR, mem_pkg::decode_op;
#(
  parameter int WORD_SIZE = mem_pkg::WORD_SIZE,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone,
  output logic                 BusErr
);

  // Only the low address bits select a word; higher bits wrap.
  localparam int ADDR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  mem_state_t           state;
  mem_state_t           state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_W-1:0]    cap_idx;
  logic [WORD_SIZE-1:0] cap_data;
  mem_op_t              cap_op;

  logic req;
  logic accept;
  logic last_busy;
  logic ram_we;
  logic ram_re;

  assign req       = ReadData | WriteData;
  // Requests are only taken outside BUSY; in BUSY they are re-driven copies.
  assign accept    = (state != BUSY) && req;
  // Final stall cycle: the coming edge performs the RAM access.
  assign last_busy = (state == BUSY) && (cnt == CNT_W'(1));

  // Next-state decode for the IDLE/BUSY/RESP handshake.
  // NOTE: state_nxt gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = req ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and latency counter; reset abandons any access in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= LAT_CNT;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Capture address, store data and operation when a request is accepted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cap_idx  <= '0;
      cap_data <= '0;
      cap_op   <= MEM_RD;
    end else if (accept) begin
      cap_idx  <= DataAddr[ADDR_W-1:0];
      cap_data <= DataOut;
      cap_op   <= decode_op(ReadData, WriteData);
    end
  end

  assign ram_we = last_busy && (cap_op == MEM_WR);
  assign ram_re = last_busy && (cap_op == MEM_RD);

  dmem_array #(
    .WIDTH  (WORD_SIZE),
    .DEPTH  (MEM_WORDS),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (Clock),
    .rst   (Reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cap_idx),
    .wdata (cap_data),
    .rdata (DataIn)
  );

  // The processor stalls exactly while the FSM is in BUSY.
  assign DataDone = (state != BUSY);

`ifdef DMEM_ERR_CHECK_EN
  logic [WORD_SIZE-1:0] cap_addr;
  logic                 cap_rd;
  logic                 cap_wr;
  logic                 err_nxt;
  logic                 bus_err;

  // Keep the full request as seen at capture for comparison during BUSY.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cap_addr <= '0;
      cap_rd   <= 1'b0;
      cap_wr   <= 1'b0;
    end else if (accept) begin
      cap_addr <= DataAddr;
      cap_rd   <= ReadData;
      cap_wr   <= WriteData;
    end
  end

  // Flag a read/write conflict at capture, or a re-driven request that
  // no longer matches what was captured.
  always_comb begin
    err_nxt = 1'b0;
    if (accept && ReadData && WriteData) begin
      err_nxt = 1'b1;
    end else if (state == BUSY) begin
      err_nxt = (ReadData != cap_rd) || (WriteData != cap_wr) ||
                (DataAddr != cap_addr);
    end
  end

  // Register the error so BusErr is a clean single-cycle pulse per event.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= err_nxt;
    end
  end

  assign BusErr = bus_err;
`else
  assign BusErr = 1'b0;

  // Address bits above the RAM index are intentionally ignored (wrap-around).
  if (WORD_SIZE > ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^DataAddr[WORD_SIZE-1:ADDR_W];
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus short random bench for data_mem_responder. Expected load
// results come from a bench-side memory model and are queued when a load is
// issued, then popped when DataDone rises at the end of that access.
module tb_data_mem_responder;

  localparam int W   = 16;
  localparam int MW  = 256;
  localparam int LAT = 2;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] DataAddr;
  logic [W-1:0] DataOut;
  logic         ReadData;
  logic         WriteData;
  logic [W-1:0] DataIn;
  logic         DataDone;
  logic         BusErr;

  always #5 Clock = ~Clock;

  data_mem_responder #(
    .WORD_SIZE (W),
    .MEM_WORDS (MW),
    .LATENCY   (LAT)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DataAddr  (DataAddr),
    .DataOut   (DataOut),
    .ReadData  (ReadData),
    .WriteData (WriteData),
    .DataIn    (DataIn),
    .DataDone  (DataDone),
    .BusErr    (BusErr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0] model   [MW];
  bit           written [MW];
  logic [W-1:0] exp_q   [$];
  logic [W-1:0] last_load;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One access: drive the request, hold it through BUSY (DataOut may change),
  // return in the RESP cycle with the request still driven.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [W-1:0] addr, input logic [W-1:0] data,
                        input logic [W-1:0] busy_data, input logic conflict);
    logic [7:0] idx;
    idx       = addr[7:0];
    ReadData  = rd;
    WriteData = wr;
    DataAddr  = addr;
    DataOut   = data;
    if (wr) begin
      model[idx]   = data;
      written[idx] = 1'b1;
    end else begin
      exp_q.push_back(model[idx]);
    end
    step();
    check({tag, "_done_c1"}, W'(DataDone), W'(0));
    check({tag, "_err_c1"}, W'(BusErr), W'(ERR_EN && conflict));
    DataOut = busy_data;
    for (int i = 1; i < LAT; i++) begin
      step();
      check({tag, "_done_busy"}, W'(DataDone), W'(0));
      check({tag, "_err_busy"}, W'(BusErr), W'(0));
    end
    step();
    check({tag, "_done_resp"}, W'(DataDone), W'(1));
    check({tag, "_err_resp"}, W'(BusErr), W'(0));
    if (!wr) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, W'(exp_q.size()), W'(1));
      end else begin
        last_load = exp_q.pop_front();
        check({tag, "_data"}, DataIn, last_load);
      end
    end else begin
      check({tag, "_hold"}, DataIn, last_load);
    end
  endtask

  task automatic idle(input string tag);
    ReadData  = 1'b0;
    WriteData = 1'b0;
    step();
    check({tag, "_idle_done"}, W'(DataDone), W'(1));
    check({tag, "_idle_err"}, W'(BusErr), W'(0));
  endtask

  // Global bound so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] d;

    Reset     = 1'b1;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    DataAddr  = '0;
    DataOut   = '0;
    last_load = '0;
    for (int i = 0; i < MW; i++) written[i] = 1'b0;

    repeat (2) @(posedge Clock);
    #1;
    check("rst_done", W'(DataDone), W'(1));
    check("rst_data", DataIn, W'(0));
    check("rst_err", W'(BusErr), W'(0));
    Reset = 1'b0;
    step();
    step();
    check("idle_done", W'(DataDone), W'(1));
    check("idle_data", DataIn, W'(0));
    check("idle_err", W'(BusErr), W'(0));

    // Store then load the same address.
    access("st5", 1'b0, 1'b1, 16'd5, 16'hBEEF, 16'hBEEF, 1'b0);
    idle("st5");
    access("ld5", 1'b1, 1'b0, 16'd5, 16'h0000, 16'h0000, 1'b0);
    idle("ld5");

    // Address 261 wraps onto word 5.
    access("ld261", 1'b1, 1'b0, 16'd261, 16'h0000, 16'h0000, 1'b0);
    idle("ld261");

    // Back-to-back store then load with no idle gap: 0,0,1,0,0,1.
    access("b2b_st9", 1'b0, 1'b1, 16'd9, 16'h5555, 16'h5555, 1'b0);
    access("b2b_ld9", 1'b1, 1'b0, 16'd9, 16'h0000, 16'h0000, 1'b0);
    access("b2b_st200", 1'b0, 1'b1, 16'd200, 16'hA5A5, 16'hA5A5, 1'b0);
    access("b2b_ld200", 1'b1, 1'b0, 16'd200, 16'h0000, 16'h0000, 1'b0);
    idle("b2b");

    // Read and write together: treated as a store, BusErr only when enabled.
    access("conflict", 1'b1, 1'b1, 16'd17, 16'h0F0F, 16'h0F0F, 1'b1);
    idle("conflict");
    access("ld17", 1'b1, 1'b0, 16'd17, 16'h0000, 16'h0000, 1'b0);
    idle("ld17");

    // Store data changed during BUSY must not be re-captured.
    access("st30", 1'b0, 1'b1, 16'd30, 16'h1111, 16'hFFFF, 1'b0);
    idle("st30");
    access("ld30", 1'b1, 1'b0, 16'd30, 16'h0000, 16'h0000, 1'b0);
    idle("ld30");

    // Reset in the middle of a store: store abandoned, old value kept.
    ReadData  = 1'b0;
    WriteData = 1'b1;
    DataAddr  = 16'd9;
    DataOut   = 16'h1234;
    step();
    check("rstbusy_done_pre", W'(DataDone), W'(0));
    Reset = 1'b1;
    #1;
    check("rstbusy_done", W'(DataDone), W'(1));
    check("rstbusy_data", DataIn, W'(0));
    check("rstbusy_err", W'(BusErr), W'(0));
    ReadData  = 1'b0;
    WriteData = 1'b0;
    step();
    Reset     = 1'b0;
    last_load = '0;
    step();
    check("rstbusy_idle", W'(DataDone), W'(1));
    access("ld9_after_rst", 1'b1, 1'b0, 16'd9, 16'h0000, 16'h0000, 1'b0);
    idle("ld9_after_rst");

    // Short random mix of stores and loads, some back-to-back, with wrap.
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom_range(0, 31)) | ($urandom_range(0, 1) != 0 ? 16'h0100 : 16'h0000);
      d = W'($urandom);
      if (written[a[7:0]] && ($urandom_range(0, 1) != 0)) begin
        access("rnd_ld", 1'b1, 1'b0, a, 16'h0000, 16'h0000, 1'b0);
      end else begin
        access("rnd_st", 1'b0, 1'b1, a, d, d, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) idle("rnd");
    end
    idle("end");

    check("sb_drained", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
